// File: rtl/fp_window_accum_if.sv
// Operand/result channel of the window accumulator.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid holds its payload steady until that edge, and ready never depends on valid.
`timescale 1ns/1ps
interface fp_window_accum_if #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_sign;
  logic [EXPONENT_WIDTH-1:0] in_exponent;
  logic [MANTISSA_WIDTH-1:0] in_prod;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_sign;
  logic [EXPONENT_WIDTH-1:0] out_exponent;
  logic [MANTISSA_WIDTH-1:0] out_mantissa;

  modport master (
    output in_valid, in_sign, in_exponent, in_prod, out_ready,
    input  in_ready, out_valid, out_sign, out_exponent, out_mantissa
  );

  modport slave (
    input  in_valid, in_sign, in_exponent, in_prod, out_ready,
    output in_ready, out_valid, out_sign, out_exponent, out_mantissa
  );
endinterface

// File: rtl/fp_window_accum.sv
// Sums TERMS consecutive {sign, exponent, fraction} products into one window result.
// Each term walks IDLE -> ALIGN -> ADD -> NORM; truncating arithmetic, no denormals.
`timescale 1ns/1ps
module fp_window_accum #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int TERMS          = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_window_accum_if.slave bus,
  output logic [2:0]       dbg_state
);
  localparam int E   = EXPONENT_WIDTH;
  localparam int M   = MANTISSA_WIDTH;
  localparam int SW  = M + 2;
  localparam int EW  = E + 2;
  localparam int CW  = $clog2(TERMS + 1);
  localparam int LZW = $clog2(SW);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << E) - 2);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;
  state_t state, state_nx;

  logic [CW-1:0]         count;
  logic                  acc_sign;
  logic [E-1:0]          acc_exp;
  logic [M-1:0]          acc_frac;
  logic                  op_sign;
  logic [E-1:0]          op_exp;
  logic [M-1:0]          op_frac;
  logic                  sign_a, sign_b, sum_sign;
  logic [SW-1:0]         sig_a, sig_b, sum_sig;
  logic signed [EW-1:0]  work_exp;

  logic                  al_sign_a, al_sign_b;
  logic [SW-1:0]         al_sig_a, al_sig_b, acc_sig, op_sig;
  logic [E-1:0]          diff;
  logic signed [EW-1:0]  al_exp;
  logic                  add_sign;
  logic [SW-1:0]         add_sig;
  logic [LZW-1:0]        lz;
  logic [SW-1:0]         norm_sig;
  logic signed [EW-1:0]  norm_exp;
  logic                  n_sign;
  logic [E-1:0]          n_exp;
  logic [M-1:0]          n_frac;

  // Operand "a" always carries the larger exponent; "b" is shifted down to it.
  always_comb begin
    acc_sig   = (acc_exp == '0) ? '0 : {2'b01, acc_frac};
    op_sig    = (op_exp == '0) ? '0 : {2'b01, op_frac};
    diff      = '0;
    al_sign_a = acc_sign;
    al_sig_a  = acc_sig;
    al_sign_b = op_sign;
    al_sig_b  = op_sig;
    al_exp    = {2'b00, acc_exp};
    if (op_exp == '0) begin
      al_sig_b = '0;
    end else if (acc_exp == '0) begin
      al_sign_a = op_sign;
      al_sig_a  = op_sig;
      al_sign_b = acc_sign;
      al_sig_b  = '0;
      al_exp    = {2'b00, op_exp};
    end else if (op_exp > acc_exp) begin
      diff      = op_exp - acc_exp;
      al_sign_a = op_sign;
      al_sig_a  = op_sig;
      al_sign_b = acc_sign;
      al_sig_b  = (int'(diff) > M + 1) ? '0 : (acc_sig >> diff);
      al_exp    = {2'b00, op_exp};
    end else begin
      diff      = acc_exp - op_exp;
      al_sig_b  = (int'(diff) > M + 1) ? '0 : (op_sig >> diff);
    end
  end

  always_comb begin
    add_sig  = '0;
    add_sign = 1'b0;
    if (sign_a == sign_b) begin
      add_sig  = sig_a + sig_b;
      add_sign = sign_a;
    end else if (sig_a >= sig_b) begin
      add_sig  = sig_a - sig_b;
      add_sign = sign_a;
    end else begin
      add_sig  = sig_b - sig_a;
      add_sign = sign_b;
    end
    if (add_sig == '0) add_sign = 1'b0;
  end

  // Leading-zero count below the carry bit; the highest set bit wins.
  always_comb begin
    lz = '0;
    for (int i = 0; i <= SW - 2; i++) begin
      if (sum_sig[i]) lz = LZW'(SW - 2 - i);
    end
    if (sum_sig[SW-1]) begin
      norm_sig = sum_sig >> 1;
      norm_exp = work_exp + EXP_ONE;
    end else begin
      norm_sig = sum_sig << lz;
      norm_exp = work_exp - EW'(lz);
    end
    n_sign = sum_sign;
    n_exp  = norm_exp[E-1:0];
    n_frac = norm_sig[M-1:0];
    if (norm_sig == '0 || norm_exp < EXP_ONE) begin
      n_sign = 1'b0;
      n_exp  = '0;
      n_frac = '0;
    end else if (norm_exp > EXP_MAX) begin
      n_exp  = EXP_MAX[E-1:0];
      n_frac = '1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = (count == CW'(TERMS)) ? OUT : IDLE;
      OUT:     if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      acc_sign <= 1'b0;
      acc_exp  <= '0;
      acc_frac <= '0;
      op_sign  <= 1'b0;
      op_exp   <= '0;
      op_frac  <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      sig_a    <= '0;
      sig_b    <= '0;
      work_exp <= '0;
      sum_sig  <= '0;
      sum_sign <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_sign <= bus.in_sign;
          op_exp  <= bus.in_exponent;
          op_frac <= bus.in_prod;
          count   <= count + CW'(1);
        end
        ALIGN: begin
          sign_a   <= al_sign_a;
          sign_b   <= al_sign_b;
          sig_a    <= al_sig_a;
          sig_b    <= al_sig_b;
          work_exp <= al_exp;
        end
        ADD: begin
          sum_sig  <= add_sig;
          sum_sign <= add_sign;
        end
        NORM: begin
          acc_sign <= n_sign;
          acc_exp  <= n_exp;
          acc_frac <= n_frac;
        end
        OUT: if (bus.out_ready) begin
          acc_sign <= 1'b0;
          acc_exp  <= '0;
          acc_frac <= '0;
          count    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = (state == OUT);
  assign bus.out_sign     = (state == OUT) ? acc_sign : 1'b0;
  assign bus.out_exponent = (state == OUT) ? acc_exp : '0;
  assign bus.out_mantissa = (state == OUT) ? acc_frac : '0;
  assign dbg_state        = state;
endmodule

// File: tb/tb_fp_window_accum.sv
// Directed-vector bench for fp_window_accum: value-level model, scoreboard and
// a single compare process that also checks hold stability and ready/valid exclusion.
`timescale 1ns/1ps
module tb_fp_window_accum;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  logic [W-1:0] exp_q[$];
  string        chk_name[$];
  logic [W-1:0] chk_got[$];
  logic [W-1:0] chk_exp[$];
  logic [W-1:0] win[9];

  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_word = '0;
  logic [W-1:0] word, want, cg, ce;
  string        cn;

  fp_window_accum_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) bus ();

  fp_window_accum #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .TERMS(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Value-level reference: signed integer significands, truncating alignment.
  function automatic logic [W-1:0] model_window(input logic [W-1:0] ops[9]);
    int     sa, ea, so, eo, e, d;
    longint ga, go, v;
    logic [W-1:0] w;
    sa = 0; ea = 0; ga = 0;
    for (int k = 0; k < 9; k++) begin
      w  = ops[k];
      so = int'(w[31]);
      eo = int'(w[30:23]);
      go = (eo == 0) ? 0 : ((64'sd1 << 23) + longint'(w[22:0]));
      if (ea == 0) e = eo;
      else if (eo == 0) e = ea;
      else begin
        e = (ea > eo) ? ea : eo;
        d = (ea > eo) ? ea - eo : eo - ea;
        if (ea > eo) go = (d > 24) ? 0 : (go >> d);
        else         ga = (d > 24) ? 0 : (ga >> d);
      end
      v  = (sa != 0 ? -ga : ga) + (so != 0 ? -go : go);
      sa = (v < 0) ? 1 : 0;
      ga = (v < 0) ? -v : v;
      if (ga == 0) begin
        sa = 0; ea = 0;
      end else begin
        if (ga >= (64'sd1 << 24)) begin ga = ga >> 1; e = e + 1; end
        while (ga < (64'sd1 << 23)) begin ga = ga << 1; e = e - 1; end
        if (e > 254) begin
          e = 254; ga = (64'sd1 << 24) - 1;
        end else if (e < 1) begin
          sa = 0; e = 0; ga = 0;
        end
        ea = e;
      end
    end
    return {sa[0], ea[7:0], ga[22:0]};
  endfunction

  function automatic void push_chk(input string n, input logic [W-1:0] g, input logic [W-1:0] e);
    chk_name.push_back(n);
    chk_got.push_back(g);
    chk_exp.push_back(e);
  endfunction

  // Single compare process, sampled mid-low-phase when inputs and outputs are settled.
  always @(negedge clk) begin
    #2;
    while (chk_name.size() > 0) begin
      cn = chk_name.pop_front();
      cg = chk_got.pop_front();
      ce = chk_exp.pop_front();
      n_tests++;
      if (cg !== ce) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", cn, cg, ce);
      end
    end
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      word = {bus.out_sign, bus.out_exponent, bus.out_mantissa};
      n_tests++;
      if (bus.in_ready && bus.out_valid) begin
        n_fail++;
        $display("FAIL ready_valid_overlap: got in_ready=1 out_valid=1 expected not both");
      end
      if (prev_hold) begin
        n_tests++;
        if (!bus.out_valid || word !== prev_word) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%b %h expected valid=1 %h", bus.out_valid, word, prev_word);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h expected no output", word);
        end else begin
          want = exp_q.pop_front();
          if (word !== want) begin
            n_fail++;
            $display("FAIL window_sum: got %h expected %h", word, want);
          end
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_word = word;
    end
  end

  task automatic send_op(input logic [W-1:0] w, output int t);
    int guard;
    guard = 0;
    t = -1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    {bus.in_sign, bus.in_exponent, bus.in_prod} = w;
    while (!bus.in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) push_chk("accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk);
      #1 t = cyc;
    end
  endtask

  task automatic fill(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] rest);
    win[0] = a;
    win[1] = b;
    for (int k = 2; k < 9; k++) win[k] = rest;
  endtask

  task automatic run_window(input string n, input logic [W-1:0] lit, input int hold);
    logic [W-1:0] m;
    int t, tp;
    m = model_window(win);
    push_chk({n, "_model"}, m, lit);
    exp_q.push_back(m);
    if (hold > 0) bus.out_ready = 1'b0;
    tp = -1;
    for (int k = 0; k < 9; k++) begin
      send_op(win[k], t);
      if (k > 0) push_chk({n, "_spacing"}, W'(t - tp), 32'd4);
      tp = t;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 push_chk({n, "_early"}, W'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 push_chk({n, "_latency"}, W'(bus.out_valid), 32'd1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        bus.in_valid    = i[0];
        bus.in_sign     = 1'b0;
        bus.in_exponent = 8'd127;
        bus.in_prod     = 23'd0;
        push_chk({n, "_hold_in_ready"}, W'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1 push_chk({n, "_release"}, W'({bus.out_valid, bus.in_ready}), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    bus.in_valid    = 1'b0;
    bus.in_sign     = 1'b0;
    bus.in_exponent = '0;
    bus.in_prod     = '0;
    bus.out_ready   = 1'b1;
    rst_n           = 1'b0;
    repeat (2) @(negedge clk);
    push_chk("reset_out_valid", W'(bus.out_valid), 32'd0);
    push_chk("reset_in_ready", W'(bus.in_ready), 32'd1);
    push_chk("reset_outputs", {bus.out_sign, bus.out_exponent, bus.out_mantissa}, 32'd0);
    rst_n = 1'b1;

    fill(32'h3F800000, 32'h3F800000, 32'h3F800000);
    run_window("nine_ones", 32'h41100000, 0);
    fill(32'h40000000, 32'hBF000000, 32'h00000000);
    run_window("left_norm", 32'h3FC00000, 0);
    fill(32'h3FC00000, 32'hBFC00000, 32'h00000000);
    run_window("cancel", 32'h00000000, 0);
    fill(32'h3F800000, 32'h30800000, 32'h00000000);
    run_window("align_flush", 32'h3F800000, 0);
    fill(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000);
    run_window("clamp_pos", 32'h7F7FFFFF, 0);
    fill(32'hFF7FFFFF, 32'hFF7FFFFF, 32'h00000000);
    run_window("clamp_neg", 32'hFF7FFFFF, 0);
    win[0] = 32'h40400000; win[1] = 32'hBFA00000; win[2] = 32'h3F400000;
    win[3] = 32'h3E800000; win[4] = 32'hC0000000; win[5] = 32'h3F000000;
    win[6] = 32'h00000000; win[7] = 32'h41200000; win[8] = 32'hC1200000;
    run_window("mixed", 32'h3FA00000, 0);
    fill(32'h3F800000, 32'h3F800000, 32'h3F800000);
    run_window("backpressure", 32'h41100000, 10);
    run_window("after_bp", 32'h41100000, 0);

    for (int k = 0; k < 4; k++) send_op(32'h3F800000, t);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    push_chk("midrst_out_valid", W'(bus.out_valid), 32'd0);
    push_chk("midrst_in_ready", W'(bus.in_ready), 32'd1);
    push_chk("midrst_outputs", {bus.out_sign, bus.out_exponent, bus.out_mantissa}, 32'd0);
    #2 rst_n = 1'b1;
    fill(32'h40000000, 32'h40000000, 32'h40000000);
    run_window("nine_twos", 32'h41900000, 0);

    push_chk("scoreboard_empty", W'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_window_accum.md
# fp_window_accum

Floating-point accumulator directly downstream of the IEEE-style multiplier stage in the CNN datapath. It consumes one `{sign, exponent, prod}` product per handshake and sums `TERMS` consecutive products, one convolution window, into a single result of the same format. It presents the result to the next layer stage with a valid/ready handshake. It is a multi-cycle FSM with fixed per-term latency: truncating arithmetic, no denormals, no NaN/Inf.

## Interface
Parameters:
- `EXPONENT_WIDTH`, default 8: exponent field width; bias = 2^(EXPONENT_WIDTH-1)-1.
- `MANTISSA_WIDTH`, default 23: stored fraction width; hidden 1 is implicit.
- `TERMS`, default 9: products per window (3x3 kernel); must be ≥1.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `in_valid`: input, 1 bit. Product operand valid.
- `in_ready`: output, 1 bit. Block accepts an operand this cycle.
- `in_sign`: input, 1 bit. Operand sign.
- `in_exponent`: input, `EXPONENT_WIDTH` bits. Biased exponent; 0 means operand is zero.
- `in_prod`: input, `MANTISSA_WIDTH` bits. Operand fraction.
- `out_valid`: output, 1 bit. Window sum valid.
- `out_ready`: input, 1 bit. Downstream accepts the sum.
- `out_sign`: output, 1 bit. Sum sign.
- `out_exponent`: output, `EXPONENT_WIDTH` bits. Sum biased exponent.
- `out_mantissa`: output, `MANTISSA_WIDTH` bits. Sum fraction.

## Operation
- Accumulator holds sign, exponent and fraction. Exponent 0 means +0 regardless of the fraction.
- Working significand is `MANTISSA_WIDTH+2` bits: carry, hidden 1, fraction. Working exponent is signed, `EXPONENT_WIDTH+2` bits.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`, latch the operand, increment `count`, go to ALIGN.
  - ALIGN: a zero operand (exp 0) or zero accumulator contributes nothing. Otherwise right-shift the smaller-exponent significand by the exponent difference. A difference greater than MANTISSA_WIDTH+1 makes that significand zero. Shifted-out bits are discarded (truncate). Go to ADD.
  - ADD: equal signs add magnitudes. Unequal signs subtract smaller magnitude from larger and take the sign of the larger. An exactly-zero difference gives +0. Go to NORM.
  - NORM: if the carry bit is set, shift right 1 and exp+1. Otherwise left-shift by the leading-zero count via a single-cycle priority encoder, decrementing exp by that count.
    - Exp > 2^EXPONENT_WIDTH-2: clamp to exp 2^EXPONENT_WIDTH-2, fraction all ones, sign kept.
    - Exp < 1 or significand zero: +0.
    - Write the accumulator. If `count`==TERMS go to OUT, else IDLE.
  - OUT: `out_valid`=1, outputs driven from the accumulator, `in_ready`=0. On `out_ready`, clear the accumulator to +0, set `count`=0, go to IDLE.
- `in_valid` is ignored outside IDLE. Input data are sampled only on the accepting edge.
- No rounding. Result is deterministic for a given operand order.

## Timing
- Reset values (async, immediate): state IDLE, `count` 0, accumulator +0, `out_valid` 0, `out_sign`/`out_exponent`/`out_mantissa` 0, `in_ready` 1.
- Per-term occupancy is 4 cycles: accept, ALIGN, ADD, NORM. Maximum input throughput is 1 operand per 4 cycles.
- Latency: last operand accepted at edge t, then `out_valid` rises after edge t+3 and is visible in cycle t+4.
- Outputs stay stable while `out_valid`=1 and `out_ready`=0, for unlimited backpressure.
- `out_valid` drops on the edge where `out_valid`&`out_ready`. `in_ready` is 1 the following cycle.
- Reset mid-window discards partial sums and the count. No output is produced for the aborted window.
- `in_ready` and `out_valid` are never 1 in the same cycle.

## Test plan
- Nine operands of 1.0 (s0, e127, m0), back-to-back `in_valid`, `out_ready`=1 -> one `out_valid` pulse 4 cycles after the 9th accept with s0, e130, m 0x100000 (9.0). `in_ready` toggles 1-of-4 cycles.
- Operands +2.0 (e128), -0.5 (e126 m0), then seven zeros (e0) -> s0, e127, m 0x400000 (1.5), exercising left normalization. A second window of +1.5, -1.5 and seven zeros -> s0, e0, m0.
- Alignment flush: 1.0 (e127) plus 2^-30 (e97 m0) plus seven zeros -> exactly e127 m0. The 2^-30 term vanishes because diff 30 > 24.
- Overflow: two operands s0 e254 m 0x7FFFFF plus seven zeros -> clamped s0 e254 m 0x7FFFFF. The same with s1 -> s1 clamped.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` -> outputs constant, `in_ready`=0, `in_valid` pulses ignored. After `out_ready`=1 for one edge, the next 9 × 1.0 window again yields 9.0, proving the accumulator cleared.
- Reset mid-window: accept 4 × 1.0, pulse `rst_n` low asynchronously between edges -> `out_valid` 0, `in_ready` 1 immediately. The following 9 × 2.0 (e128) -> e131 m 0x100000 (18.0).
